seq_alu: RTL and testbench

- Parametrised, registered successor to the team's 6-bit combinational ALU.
- Operand width is generic. Adds arithmetic (ADD/SUB) and status flags.
- Shifts and rotates take a variable amount and run iteratively, one bit per cycle, behind valid/ready handshakes on input and output.
- Sits between the operand register file and the writeback stage in the lab datapath.

---
 rtl/seq_alu_pkg.sv | 39 +++
 rtl/seq_alu_shift_step.sv | 47 ++++
 rtl/seq_alu.sv | 173 +++++++++++++++++
 tb/tb_seq_alu.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_alu_pkg                                                        |
// | Opcode/state enums and shared helpers for the sequential ALU.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_XOR   = 4'b0010,
        OP_NOT   = 4'b0011,
        OP_SHL   = 4'b0100,
        OP_SHR   = 4'b0101,
        OP_ROL   = 4'b0110,
        OP_ROR   = 4'b0111,
        OP_ASL   = 4'b1000,
        OP_ASR   = 4'b1001,
        OP_ADD   = 4'b1010,
        OP_SUB   = 4'b1011,
        OP_PASS0 = 4'b1100,
        OP_PASS1 = 4'b1101,
        OP_PASS2 = 4'b1110,
        OP_PASS3 = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op >= OP_SHL) && (op <= OP_ASR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_shift_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_alu_shift_step                                                 |
// | Combinational one-bit shift/rotate step with shifted-out bit.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seq_alu_shift_step
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             bit_out
);

    always_comb begin
        data_out = data_in;
        bit_out  = 1'b0;
        case (op)
            OP_SHL, OP_ASL: begin
                data_out = {data_in[WIDTH-2:0], 1'b0};
                bit_out  = data_in[WIDTH-1];
            end
            OP_SHR: begin
                data_out = {1'b0, data_in[WIDTH-1:1]};
                bit_out  = data_in[0];
            end
            OP_ASR: begin
                data_out = {data_in[WIDTH-1], data_in[WIDTH-1:1]};
                bit_out  = data_in[0];
            end
            OP_ROL: begin
                data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
                bit_out  = data_in[WIDTH-1];
            end
            OP_ROR: begin
                data_out = {data_in[0], data_in[WIDTH-1:1]};
                bit_out  = data_in[0];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_alu                                                            |
// | Registered ALU with valid/ready handshakes and iterative shifts.   |
// | SEQ_ALU_BARREL_EN selects a single-cycle barrel shifter instead.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH:0] c_sum_one = {{WIDTH{1'b0}}, 1'b1};

    alu_state_e       r_state;
    alu_op_e          w_op;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic [WIDTH:0]   w_sum;
    logic             w_iter_start;

    assign w_op     = alu_op_e'(in_op);
    assign w_amt    = in_b[SHW-1:0];
    assign in_ready = (r_state == IDLE) && !rst;

`ifndef SEQ_ALU_BARREL_EN
    localparam logic [SHW-1:0] c_cnt_one = {{(SHW-1){1'b0}}, 1'b1};

    alu_op_e          r_op;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_bit;

    seq_alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .op       (r_op),
        .data_in  (r_work),
        .data_out (w_step_data),
        .bit_out  (w_step_bit)
    );

    // Zero-amount shifts finish on accept like any other op.
    assign w_iter_start = is_shift_op(w_op) && (w_amt != '0);
`else
    localparam int c_depth = (1 << SHW) - 1;

    logic [WIDTH-1:0] w_bar_data [c_depth+1];
    logic             w_bar_bit  [c_depth+1];

    assign w_bar_data[0] = in_a;
    assign w_bar_bit[0]  = 1'b0;

    // Chain covers every encodable amount, so results match the iterative path.
    for (genvar gi = 0; gi < c_depth; gi++) begin : g_stage
        seq_alu_shift_step #(.WIDTH(WIDTH)) u_step (
            .op       (w_op),
            .data_in  (w_bar_data[gi]),
            .data_out (w_bar_data[gi+1]),
            .bit_out  (w_bar_bit[gi+1])
        );
    end

    assign w_iter_start = 1'b0;
`endif

    always_comb begin
        w_sum   = '0;
        w_res   = in_a;
        w_carry = 1'b0;
        case (w_op)
            OP_AND: w_res = in_a & in_b;
            OP_OR:  w_res = in_a | in_b;
            OP_XOR: w_res = in_a ^ in_b;
            OP_NOT: w_res = ~in_a;
            OP_ADD: begin
                w_sum   = {1'b0, in_a} + {1'b0, in_b};
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_sum   = {1'b0, in_a} + {1'b0, ~in_b} + c_sum_one;
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            default: ;
        endcase
`ifdef SEQ_ALU_BARREL_EN
        if (is_shift_op(w_op)) begin
            w_res   = w_bar_data[w_amt];
            w_carry = w_bar_bit[w_amt];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
            out_carry <= 1'b0;
`ifndef SEQ_ALU_BARREL_EN
            r_op      <= OP_AND;
            r_work    <= '0;
            r_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_iter_start) begin
`ifndef SEQ_ALU_BARREL_EN
                            r_op   <= w_op;
                            r_work <= in_a;
                            r_cnt  <= w_amt;
`endif
                            r_state <= SHIFT;
                        end else begin
                            out_data  <= w_res;
                            out_carry <= w_carry;
                            out_zero  <= (w_res == '0);
                            out_neg   <= w_res[WIDTH-1];
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
`ifndef SEQ_ALU_BARREL_EN
                SHIFT: begin
                    r_work <= w_step_data;
                    r_cnt  <= r_cnt - c_cnt_one;
                    // Final step publishes directly so latency is exactly 1+N.
                    if (r_cnt == c_cnt_one) begin
                        out_data  <= w_step_data;
                        out_carry <= w_step_bit;
                        out_zero  <= (w_step_data == '0);
                        out_neg   <= w_step_data[WIDTH-1];
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_alu                                                         |
// | Scoreboard bench for seq_alu (WIDTH=8 main, WIDTH=16 side DUT).    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_seq_alu;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       z;
        logic       n;
        logic       c;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       z;
        logic       n;
        logic       c;
        int         lat;
        int         acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_zero;
    logic        out_neg;
    logic        out_carry;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] in_a16;
    logic [15:0] in_b16;
    logic [3:0]  in_op16;
    logic        out_valid16;
    logic        out_ready16;
    logic [15:0] out_data16;
    logic        out_zero16;
    logic        out_neg16;
    logic        out_carry16;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    vec_t vecs[15];

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_carry (out_carry)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_a      (in_a16),
        .in_b      (in_b16),
        .in_op     (in_op16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_data  (out_data16),
        .out_zero  (out_zero16),
        .out_neg   (out_neg16),
        .out_carry (out_carry16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] op, input int amt);
`ifdef SEQ_ALU_BARREL_EN
        return 1;
`else
        if (op >= 4'd4 && op <= 4'd9 && amt != 0) return 1 + amt;
        return 1;
`endif
    endfunction

    // Drive a request, wait for acceptance and queue the expected response.
    task automatic issue(input vec_t v);
        int   g;
        exp_t e;
        in_valid = 1'b1;
        in_op    = v.op;
        in_a     = v.a;
        in_b     = v.b;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!in_ready && g < 100);
        if (!in_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            e.d   = v.d;
            e.z   = v.z;
            e.n   = v.n;
            e.c   = v.c;
            e.lat = exp_lat(v.op, int'(v.b[2:0]));
            e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] d, input logic z, input logic n, input logic c,
                         input int lat);
        int g;
        int acc;
        in_valid16 = 1'b1;
        in_op16    = op;
        in_a16     = a;
        in_b16     = b;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!in_ready16 && g < 100);
        acc = cyc;
        @(posedge clk);
        #2;
        in_valid16 = 1'b0;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!out_valid16 && g < 100);
        if (!out_valid16) begin
            chk("w16_result_timeout", 32'd1, 32'd0);
        end else begin
            chk("w16_latency", cyc - acc, lat);
            chk("w16_out_data", out_data16, d);
            chk("w16_out_zero", out_zero16, z);
            chk("w16_out_neg", out_neg16, n);
            chk("w16_out_carry", out_carry16, c);
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares every presented result against the queue head.
    initial begin : monitor
        exp_t e;
        bit   seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        chk("latency", cyc - e.acc, e.lat);
                        seen = 1'b1;
                    end
                    chk("out_data", out_data, e.d);
                    chk("out_zero", out_zero, e.z);
                    chk("out_neg", out_neg, e.n);
                    chk("out_carry", out_carry, e.c);
                    chk("in_ready_busy", in_ready, 1'b0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        //          op       a      b      d      z     n     c
        vecs = '{
            '{4'b0000, 8'h07, 8'h15, 8'h05, 1'b0, 1'b0, 1'b0},
            '{4'b1010, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b0, 1'b1},
            '{4'b1011, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1},
            '{4'b1011, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0},
            '{4'b1001, 8'h90, 8'h03, 8'hF2, 1'b0, 1'b1, 1'b0},
            '{4'b0110, 8'h81, 8'h01, 8'h03, 1'b0, 1'b0, 1'b1},
            '{4'b0100, 8'hFF, 8'h07, 8'h80, 1'b0, 1'b1, 1'b1},
            '{4'b0101, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0},
            '{4'b0001, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b1, 1'b0},
            '{4'b0010, 8'h3C, 8'h0F, 8'h33, 1'b0, 1'b0, 1'b0},
            '{4'b0011, 8'h0F, 8'h99, 8'hF0, 1'b0, 1'b1, 1'b0},
            '{4'b1111, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0},
            '{4'b0111, 8'h01, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1},
            '{4'b0101, 8'h81, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0},
            '{4'b1000, 8'h41, 8'h02, 8'h04, 1'b0, 1'b0, 1'b1}
        };

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_op       = 4'd0;
        in_a        = 8'd0;
        in_b        = 8'd0;
        out_ready   = 1'b1;
        in_valid16  = 1'b0;
        in_op16     = 4'd0;
        in_a16      = 16'd0;
        in_b16      = 16'd0;
        out_ready16 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 8'h00);
        chk("reset_flags", {out_zero, out_neg, out_carry}, 3'b000);
        chk("reset_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #2;

        foreach (vecs[i]) issue(vecs[i]);
        drain();

        // Back-pressure: result must hold and new requests must be refused.
        out_ready = 1'b0;
        issue('{4'b0010, 8'hC3, 8'h0F, 8'hCC, 1'b0, 1'b1, 1'b0});
        in_valid = 1'b1;
        in_op    = 4'b0001;
        in_a     = 8'h11;
        in_b     = 8'h22;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1'b1);
        chk("bp_release_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #2;
        issue('{4'b0001, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0});
        drain();

        // Reset during an in-flight SHL by 6.
        out_ready = 1'b0;
        issue('{4'b0100, 8'h03, 8'h06, 8'hC0, 1'b0, 1'b1, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_data", out_data, 8'h00);
        chk("abort_flags", {out_zero, out_neg, out_carry}, 3'b000);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_abort_in_ready", in_ready, 1'b1);
        chk("post_abort_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #2;
        issue('{4'b1010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0});
        drain();

        // WIDTH=16 instance: wide shift amounts and wide carry.
        run16(4'b0111, 16'h0001, 16'd9,  16'h0080, 1'b0, 1'b0, 1'b0, exp_lat(4'b0111, 9));
        run16(4'b1010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1);
        run16(4'b1001, 16'h8000, 16'd15, 16'hFFFF, 1'b0, 1'b1, 1'b0, exp_lat(4'b1001, 15));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
